// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: base^exponent mod modulus via right-to-left square-and-multiply on a bit-serial interleaved modular multiplier
module rsa_modexp_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             ready,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, STEP, MULR, SQR, FINISH} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] b, e, m, r;
    logic [WIDTH+1:0] acc, acc2, acc3, acc4, m_ext;
    logic [CW-1:0] cnt;
    logic bad, last, xb;
    assign bad = modulus < WIDTH'(2) || base >= modulus;
    assign last = cnt == '0;
    assign m_ext = {2'b00, m};
    // MULR walks R's bits, SQR walks B's bits; Y is B in both cases
    assign xb = state == SQR ? b[cnt] : r[cnt];
    assign acc2 = (acc << 1) + (xb ? {2'b00, b} : '0);
    assign acc3 = acc2 >= m_ext ? acc2 - m_ext : acc2;
    assign acc4 = acc3 >= m_ext ? acc3 - m_ext : acc3;
    always_comb begin
        state_n = state;
        ready = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                state_n = start ? (bad ? FINISH : STEP) : IDLE;
            end
            STEP: state_n = e == '0 ? FINISH : (e[0] ? MULR : SQR);
            MULR: state_n = last ? SQR : MULR;
            SQR: state_n = last ? STEP : SQR;
            FINISH: begin
                done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            b <= '0;
            e <= '0;
            m <= '0;
            r <= '0;
            acc <= '0;
            cnt <= '0;
            error <= 1'b0;
            result <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    b <= base;
                    e <= exponent;
                    m <= modulus;
                    r <= WIDTH'(1);
                    acc <= '0;
                    cnt <= CW'(WIDTH - 1);
                    error <= bad;
                    if (bad) result <= '0;
                end
                STEP: if (e == '0) result <= r;
                MULR, SQR: begin
                    acc <= last ? '0 : acc4;
                    cnt <= last ? CW'(WIDTH - 1) : cnt - 1'b1;
                    if (last && state == MULR) r <= acc4[WIDTH-1:0];
                    if (last && state == SQR) begin
                        b <= acc4[WIDTH-1:0];
                        e <= e >> 1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: table, random and corner-case checks of the exponentiation engine against an arithmetic model
module tb_rsa_modexp_core;
    logic clk = 1'b0, reset = 1'b1;
    logic start16 = 1'b0, ready16, done16, error16;
    logic [15:0] base16 = '0, exp16 = '0, mod16 = '0, result16;
    logic start32 = 1'b0, ready32, done32, error32;
    logic [31:0] base32 = '0, exp32 = '0, mod32 = '0, result32;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rsa_modexp_core #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(start16), .base(base16), .exponent(exp16),
        .modulus(mod16), .ready(ready16), .done(done16), .error(error16), .result(result16)
    );
    rsa_modexp_core #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .base(base32), .exponent(exp32),
        .modulus(mod32), .ready(ready32), .done(done32), .error(error32), .result(result32)
    );

    typedef struct {
        logic [15:0] b, e, m, res;
        logic err;
        int lat;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned mexp(longint unsigned b, longint unsigned e, longint unsigned m);
        longint unsigned r = 1;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    function automatic int exp_lat(longint unsigned e, int w, bit err);
        int l = 0, h = 0;
        if (err) return 1;
        for (int i = 0; i < 64; i++) if (e[i]) begin l = i + 1; h++; end
        return l + 2 + w * (h + l);
    endfunction

    // hold keeps start high with scrambled operands for the whole run
    task automatic run16(input logic [15:0] b, e, m, input bit hold, output int lat,
                         output logic [15:0] res, output logic err);
        int rdy_hi = 0;
        @(negedge clk);
        chk("ready_at_start16", ready16, 1);
        start16 = 1'b1; base16 = b; exp16 = e; mod16 = m;
        @(negedge clk);
        lat = 1;
        start16 = hold;
        while (!done16 && lat < 3000) begin
            if (ready16) rdy_hi++;
            if (hold) begin base16 = 16'($urandom); exp16 = 16'($urandom); mod16 = 16'($urandom); end
            @(negedge clk);
            lat++;
        end
        start16 = 1'b0;
        if (!done16) begin
            bad++;
            $display("FAIL timeout16: got no done want done");
        end
        chk("ready_low16", rdy_hi, 0);
        res = result16;
        err = error16;
    endtask

    task automatic job16(input string name, input logic [15:0] b, e, m, input logic [15:0] xres,
                         input logic xerr, input int xlat, input bit hold);
        int lat;
        logic [15:0] res;
        logic err;
        run16(b, e, m, hold, lat, res, err);
        chk({name, "_lat"}, lat, xlat);
        chk({name, "_res"}, res, xres);
        chk({name, "_err"}, err, xerr);
    endtask

    task automatic job32(input logic [31:0] b, e, m);
        int lat = 1;
        @(negedge clk);
        start32 = 1'b1; base32 = b; exp32 = e; mod32 = m;
        @(negedge clk);
        start32 = 1'b0;
        while (!done32 && lat < 3000) begin @(negedge clk); lat++; end
        chk("w32_lat", lat, exp_lat(e, 32, 0));
        chk("w32_res", result32, mexp(b, e, m));
        chk("w32_err", error32, 0);
    endtask

    initial begin
        int dones;
        logic [15:0] rb, re, rm;
        vecs[0] = '{16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 118};
        vecs[1] = '{16'd7, 16'd0, 16'd13, 16'd1, 1'b0, 2};
        vecs[2] = '{16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, 102};
        vecs[3] = '{16'd5, 16'd7, 16'd1, 16'd0, 1'b1, 1};
        vecs[4] = '{16'd13, 16'd5, 16'd13, 16'd0, 1'b1, 1};
        vecs[5] = '{16'd3, 16'd1, 16'd7, 16'd3, 1'b0, 35};
        vecs[6] = '{16'd2, 16'd3, 16'd0, 16'd0, 1'b1, 1};
        vecs[7] = '{16'd0, 16'd5, 16'd11, 16'd0, 1'b0, 85};
        vecs[8] = '{16'd65534, 16'd2, 16'd65535, 16'd1, 1'b0, 52};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", ready16, 1);
        chk("rst_done", done16, 0);
        chk("rst_error", error16, 0);
        chk("rst_result", result16, 0);
        chk("rst_ready32", ready32, 1);

        // consecutive entries also exercise back-to-back starts and error clearing
        for (int i = 0; i < 9; i++)
            job16($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].m,
                  vecs[i].res, vecs[i].err, vecs[i].lat, 0);

        for (int i = 0; i < 20; i++) begin
            rm = 16'($urandom_range(2, 65535));
            rb = 16'($urandom_range(0, int'(rm) - 1));
            re = 16'($urandom);
            job16($sformatf("rnd%0d", i), rb, re, rm, 16'(mexp(rb, re, rm)), 0, exp_lat(re, 16, 0), 0);
        end

        job32(32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF);
        job32(32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        chk("w32_res3_const", result32, 32'hFFFF_FFFE);

        job16("hold", 16'd4, 16'd13, 16'd497, 16'd445, 0, 118, 1);
        dones = 0;
        repeat (6) begin @(negedge clk); if (done16) dones++; end
        chk("hold_extra_done", dones, 0);

        @(negedge clk);
        start16 = 1'b1; base16 = 16'd4; exp16 = 16'd13; mod16 = 16'd497;
        @(negedge clk);
        start16 = 1'b0;
        dones = 0;
        repeat (49) begin @(negedge clk); if (done16) dones++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", ready16, 1);
        chk("abort_result", result16, 0);
        chk("abort_error", error16, 0);
        repeat (150) begin if (done16) dones++; @(negedge clk); end
        chk("abort_done", dones, 0);
        job16("after_abort", 16'd3, 16'd200, 16'd1009, 16'(mexp(3, 200, 1009)), 0, exp_lat(200, 16, 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rsa_modexp_core.md
# rsa_modexp_core

Parametrised modular-exponentiation engine computing result = base^exponent mod modulus for the RSA RFID tag/reader datapath. It is the next-generation exponentiation block. It adds operand width as a parameter, a start/ready/done handshake, operand validation with an error flag, and a deterministic, data-dependent cycle count. It sits between the tag controller's load logic and the output mux, and is used for both encryption and decryption; only the exponent differs.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- clk  in  1  rising-edge clock; all state changes on this edge.
- reset  in  1  synchronous, active-high; sampled on clk edge.
- start  in  1  request; accepted only on a cycle where ready=1.
- base  in  WIDTH  message/ciphertext; sampled when start is accepted.
- exponent  in  WIDTH  public or private key; sampled when start is accepted.
- modulus  in  WIDTH  RSA modulus n; sampled when start is accepted.
- ready  out  1  engine idle and able to accept start.
- done  out  1  single-cycle pulse; result/error valid from this cycle.
- error  out  1  operands rejected; valid with done, held until next accept.
- result  out  WIDTH  exponentiation result; held until next accepted start.

## Operation
- Reset values: ready=1, done=0, error=0, result=0, state IDLE, all internal registers 0.
- States: IDLE, STEP, MULR, SQR, FINISH.
- IDLE: ready=1. A start while ready=1 latches base→B, exponent→E, modulus→M, and sets R=1.
  - If modulus<2 or base>=modulus: set error=1 and result=0, then go to FINISH.
  - Otherwise: clear error and go to STEP.
  - start in any other state is ignored; inputs are not re-sampled.
- STEP (1 cycle): if E==0 go to FINISH; else if E[0]==1 go to MULR; else go to SQR.
- MULR (WIDTH cycles): R ← R·B mod M.
- SQR (WIDTH cycles): B ← B·B mod M; in the last cycle, E ← E>>1; then go to STEP.
- FINISH (1 cycle): done=1; result ← R (error path: result=0); next state is IDLE. ready=0 in FINISH.
- Modular multiply X·Y mod M is interleaved, MSB-first over X, one bit per cycle, on an accumulator A of WIDTH+2 bits:
  - A ← 2A + (x_i ? Y : 0).
  - Then subtract M up to twice until A<M.
  - A starts at 0. A bit counter runs WIDTH−1 down to 0.
  - Invariant: A<M after every cycle. No overflow is possible, since 2A+Y < 3M < 2^(WIDTH+2).
- Arithmetic is unsigned throughout. The multiplier reuses one accumulator/subtractor pair for MULR and SQR.
- reset mid-operation aborts on that edge. The engine returns to the reset values with no done pulse, and the partial result is discarded.
- reset and start in the same cycle: reset wins and the start is dropped.

## Timing
- Let T be the accepting edge, L the index of the exponent's highest set bit plus 1 (0 if exponent=0), and H the popcount of the exponent.
- Valid path: done is high in cycle T + L + 2 + WIDTH·(H+L).
- Error path: done is high in cycle T+1.
- exponent=0 with valid operands: done at T+2, result=1.
- ready falls the cycle after T and returns high the cycle after done.
- Earliest back-to-back start: the cycle after done.
- result and error are stable from done until the edge that accepts the next start.
- The worst case for WIDTH=32 (exponent all ones) is 32+2+32·64 = 2082 cycles.

## Test plan
- WIDTH=16: base=4, exponent=13, modulus=497 -> done exactly 118 cycles after accept, result=445, error=0; ready low throughout.
- WIDTH=16: base=7, exponent=0, modulus=13 -> done at T+2, result=1. Then a back-to-back start the cycle after done with base=2, exponent=10, modulus=1000 -> result=24.
- WIDTH=16: modulus=1, and separately base=13 with modulus=13 -> done at T+1, error=1, result=0. A following valid job clears error.
- WIDTH=32: base=0xFFFFFFFE, exponent=2, modulus=0xFFFFFFFF -> result=1. Also 0xFFFFFFFE^3 mod 0xFFFFFFFF = 0xFFFFFFFE. Checks the accumulator carry headroom.
- start asserted continuously during a run with changed operands -> ignored; the result matches the originally latched operands, and only one done pulse occurs.
- reset pulsed 50 cycles into a job -> next cycle ready=1, result=0, error=0, no done pulse. A new job then completes with the correct value.
